// File: rtl/ftile_tx_ts_fp_tracker_if.sv
// Request / MAC-timestamp / completion bundle between TX DMA, F-tile MAC and the fingerprint tracker.
interface ftile_tx_ts_fp_tracker_if #(
   parameter int unsigned FP_W = 20,
   parameter int unsigned TS_W = 96
);
   logic            req_valid;
   logic [FP_W-1:0] req_fingerprint;
   logic            mac_ts_valid;
   logic [FP_W-1:0] mac_ts_fingerprint;
   logic [TS_W-1:0] mac_ts_data;
   logic            o_ts_valid;
   logic [FP_W-1:0] o_ts_fingerprint;
   logic [TS_W-1:0] o_ts_data;

   modport master (
      output req_valid, req_fingerprint, mac_ts_valid, mac_ts_fingerprint, mac_ts_data,
      input  o_ts_valid, o_ts_fingerprint, o_ts_data
   );

   modport slave (
      input  req_valid, req_fingerprint, mac_ts_valid, mac_ts_fingerprint, mac_ts_data,
      output o_ts_valid, o_ts_fingerprint, o_ts_data
   );
endinterface

// File: rtl/ftile_tx_ts_fp_tracker.sv
// Queues TX timestamp request fingerprints, matches in-order MAC egress stamps, times out lost ones.
// Optional statistics counters are built when TX_TS_TRACK_STATS_EN is defined.
module ftile_tx_ts_fp_tracker #(
   parameter int unsigned FP_W        = 20,
   parameter int unsigned TS_W        = 96,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                       clk,
   input  logic                       reset_n,
   ftile_tx_ts_fp_tracker_if.slave    bus,
   output logic [$clog2(DEPTH):0]     outstanding,
   input  logic                       sticky_clr,
   output logic                       sticky_ovf,
   output logic                       sticky_unmatched,
   output logic                       sticky_timeout,
   output logic [31:0]                cnt_matched,
   output logic [31:0]                cnt_timeout,
   output logic [31:0]                cnt_unmatched,
   output logic [31:0]                cnt_ovf
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {ST_EMPTY, ST_ARMED, ST_EXPIRE} state_e;

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [FP_W-1:0]   fifo_q [DEPTH];
   logic [FP_W-1:0]   head_fp_c;
   logic              full_c;
   logic              match_c, expire_c, pop_c, push_c, ovf_c, unmatched_c;
   logic              o_valid_q;
   logic [FP_W-1:0]   o_fp_q;
   logic [TS_W-1:0]   o_data_q;
   logic              sticky_ovf_q, sticky_unmatched_q, sticky_timeout_q;

   assign head_fp_c = fifo_q[rd_ptr_q];
   assign full_c    = (count_q == CNT_W'(DEPTH));

   // Head-entry state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Next state: EXPIRE is the single cycle in which the head age equals TIMEOUT_CYC-1
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (pop_c) begin
         timer_d = '0;
         state_d = (count_d != '0) ? ST_ARMED : ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (push_c) state_d = ST_ARMED;
            ST_ARMED: begin
               timer_d = timer_q + TMR_W'(1);
               if (timer_q == TMR_W'(TIMEOUT_CYC - 2)) state_d = ST_EXPIRE;
            end
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Per-cycle actions; a match always beats a same-cycle expiry
   always_comb begin
      match_c     = 1'b0;
      expire_c    = 1'b0;
      pop_c       = 1'b0;
      push_c      = 1'b0;
      ovf_c       = 1'b0;
      unmatched_c = 1'b0;
      match_c     = bus.mac_ts_valid && (state_q != ST_EMPTY) &&
                    (bus.mac_ts_fingerprint == head_fp_c);
      unmatched_c = bus.mac_ts_valid && !match_c;
      expire_c    = (state_q == ST_EXPIRE) && !match_c;
      pop_c       = match_c || expire_c;
      push_c      = bus.req_valid && (!full_c || pop_c);
      ovf_c       = bus.req_valid && !push_c;
   end

   always_ff @(posedge clk) begin
      if (push_c) fifo_q[wr_ptr_q] <= bus.req_fingerprint;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   // Completion pulse; fingerprint/data hold between pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_valid_q <= 1'b0;
         o_fp_q    <= '0;
         o_data_q  <= '0;
      end else begin
         o_valid_q <= pop_c;
         if (pop_c) begin
            o_fp_q   <= head_fp_c;
            o_data_q <= match_c ? bus.mac_ts_data : {TS_W{1'b1}};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sticky_ovf_q       <= 1'b0;
         sticky_unmatched_q <= 1'b0;
         sticky_timeout_q   <= 1'b0;
      end else begin
         sticky_ovf_q       <= ovf_c       || (sticky_ovf_q       && !sticky_clr);
         sticky_unmatched_q <= unmatched_c || (sticky_unmatched_q && !sticky_clr);
         sticky_timeout_q   <= expire_c    || (sticky_timeout_q   && !sticky_clr);
      end
   end

`ifdef TX_TS_TRACK_STATS_EN
   logic [31:0] cnt_matched_q, cnt_timeout_q, cnt_unmatched_q, cnt_ovf_q;

   // Saturating event counters, cleared only by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_matched_q   <= '0;
         cnt_timeout_q   <= '0;
         cnt_unmatched_q <= '0;
         cnt_ovf_q       <= '0;
      end else begin
         if (match_c     && (cnt_matched_q   != '1)) cnt_matched_q   <= cnt_matched_q   + 32'd1;
         if (expire_c    && (cnt_timeout_q   != '1)) cnt_timeout_q   <= cnt_timeout_q   + 32'd1;
         if (unmatched_c && (cnt_unmatched_q != '1)) cnt_unmatched_q <= cnt_unmatched_q + 32'd1;
         if (ovf_c       && (cnt_ovf_q       != '1)) cnt_ovf_q       <= cnt_ovf_q       + 32'd1;
      end
   end

   assign cnt_matched   = cnt_matched_q;
   assign cnt_timeout   = cnt_timeout_q;
   assign cnt_unmatched = cnt_unmatched_q;
   assign cnt_ovf       = cnt_ovf_q;
`else
   assign cnt_matched   = '0;
   assign cnt_timeout   = '0;
   assign cnt_unmatched = '0;
   assign cnt_ovf       = '0;
`endif

   assign bus.o_ts_valid       = o_valid_q;
   assign bus.o_ts_fingerprint = o_fp_q;
   assign bus.o_ts_data        = o_data_q;
   assign outstanding          = count_q;
   assign sticky_ovf           = sticky_ovf_q;
   assign sticky_unmatched     = sticky_unmatched_q;
   assign sticky_timeout       = sticky_timeout_q;
endmodule

// File: tb/tb_ftile_tx_ts_fp_tracker.sv
// Directed self-checking bench for ftile_tx_ts_fp_tracker (short timeout to keep runtime small).
module tb_ftile_tx_ts_fp_tracker;
   localparam int unsigned FP_W        = 20;
   localparam int unsigned TS_W        = 96;
   localparam int unsigned DEPTH       = 16;
   localparam int unsigned TIMEOUT_CYC = 40;
   localparam int unsigned OUT_W       = $clog2(DEPTH) + 1;
`ifdef TX_TS_TRACK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk;
   logic              reset_n;
   logic              sticky_clr;
   logic [OUT_W-1:0]  outstanding;
   logic              sticky_ovf, sticky_unmatched, sticky_timeout;
   logic [31:0]       cnt_matched, cnt_timeout, cnt_unmatched, cnt_ovf;

   int n_checks = 0;
   int n_fail   = 0;
   int n_comp   = 0;
   int comp_base;

   ftile_tx_ts_fp_tracker_if #(.FP_W(FP_W), .TS_W(TS_W)) bus ();

   ftile_tx_ts_fp_tracker #(
      .FP_W(FP_W), .TS_W(TS_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .outstanding(outstanding), .sticky_clr(sticky_clr),
      .sticky_ovf(sticky_ovf), .sticky_unmatched(sticky_unmatched),
      .sticky_timeout(sticky_timeout),
      .cnt_matched(cnt_matched), .cnt_timeout(cnt_timeout),
      .cnt_unmatched(cnt_unmatched), .cnt_ovf(cnt_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (bus.o_ts_valid === 1'b1) n_comp++;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
      return STATS ? 32'(n) : 32'd0;
   endfunction

   function automatic logic [TS_W-1:0] ts_of(input int i);
      return TS_W'(64'h1234_0000_0000) + TS_W'(i);
   endfunction

   initial begin
      logic [TS_W-1:0] a5;
      a5 = {12{8'hA5}};
      reset_n = 1'b0;
      sticky_clr = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_fingerprint = '0;
      bus.mac_ts_valid = 1'b0;
      bus.mac_ts_fingerprint = '0;
      bus.mac_ts_data = '0;
      repeat (3) tick();
      check_eq("rst_valid", bus.o_ts_valid, 1'b0);
      check_eq("rst_outstanding", outstanding, 0);
      check_eq("rst_sticky", {sticky_ovf, sticky_unmatched, sticky_timeout}, 0);
      reset_n = 1'b1;
      tick();

      // 1: single request matched one cycle after becoming visible
      bus.req_valid = 1'b1; bus.req_fingerprint = 20'h00011;
      tick();
      bus.req_valid = 1'b0;
      check_eq("t1_outstanding1", outstanding, 1);
      bus.mac_ts_valid = 1'b1; bus.mac_ts_fingerprint = 20'h00011; bus.mac_ts_data = a5;
      tick();
      bus.mac_ts_valid = 1'b0;
      check_eq("t1_valid", bus.o_ts_valid, 1'b1);
      check_eq("t1_fp", bus.o_ts_fingerprint, 20'h00011);
      check_eq("t1_data", bus.o_ts_data, a5);
      check_eq("t1_outstanding0", outstanding, 0);
      check_eq("t1_cnt_matched", cnt_matched, exp_cnt(1));
      tick();
      check_eq("t1_pulse", bus.o_ts_valid, 1'b0);

      // 2: lost stamp times out TIMEOUT_CYC cycles after the push is visible
      bus.req_valid = 1'b1; bus.req_fingerprint = 20'h00001;
      tick();
      bus.req_valid = 1'b0;
      repeat (TIMEOUT_CYC - 1) tick();
      check_eq("t2_early", bus.o_ts_valid, 1'b0);
      tick();
      check_eq("t2_valid", bus.o_ts_valid, 1'b1);
      check_eq("t2_fp", bus.o_ts_fingerprint, 20'h00001);
      check_eq("t2_data", bus.o_ts_data, {TS_W{1'b1}});
      check_eq("t2_sticky", sticky_timeout, 1'b1);
      check_eq("t2_outstanding", outstanding, 0);
      check_eq("t2_cnt_timeout", cnt_timeout, exp_cnt(1));
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check_eq("t2_clr", sticky_timeout, 1'b0);

      // 3: overflow on the 17th request, then in-order drain
      for (int i = 0; i < 17; i++) begin
         bus.req_valid = 1'b1; bus.req_fingerprint = FP_W'(32'h100 + i);
         tick();
      end
      bus.req_valid = 1'b0;
      check_eq("t3_outstanding", outstanding, 16);
      check_eq("t3_sticky_ovf", sticky_ovf, 1'b1);
      check_eq("t3_cnt_ovf", cnt_ovf, exp_cnt(1));
      for (int i = 0; i < 16; i++) begin
         bus.mac_ts_valid = 1'b1;
         bus.mac_ts_fingerprint = FP_W'(32'h100 + i);
         bus.mac_ts_data = ts_of(i);
         tick();
         check_eq($sformatf("t3_fp%0d", i),
                  {bus.o_ts_valid, bus.o_ts_fingerprint}, {1'b1, FP_W'(32'h100 + i)});
         check_eq($sformatf("t3_data%0d", i), bus.o_ts_data, ts_of(i));
      end
      bus.mac_ts_valid = 1'b0;
      check_eq("t3_drained", outstanding, 0);

      // 4: mismatching stamp dropped, head preserved, sticky set/clear
      bus.req_valid = 1'b1; bus.req_fingerprint = 20'h00005;
      tick();
      bus.req_fingerprint = 20'h00006;
      tick();
      bus.req_valid = 1'b0;
      bus.mac_ts_valid = 1'b1; bus.mac_ts_fingerprint = 20'h00006; bus.mac_ts_data = ts_of(50);
      tick();
      check_eq("t4_nocomp", bus.o_ts_valid, 1'b0);
      check_eq("t4_sticky", sticky_unmatched, 1'b1);
      check_eq("t4_outstanding", outstanding, 2);
      bus.mac_ts_fingerprint = 20'h00005; bus.mac_ts_data = ts_of(51);
      tick();
      check_eq("t4_head", {bus.o_ts_valid, bus.o_ts_fingerprint}, {1'b1, 20'h00005});
      bus.mac_ts_valid = 1'b0;
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check_eq("t4_clr", {sticky_unmatched, sticky_ovf}, 2'b00);
      bus.mac_ts_valid = 1'b1; bus.mac_ts_fingerprint = 20'h00006; bus.mac_ts_data = ts_of(52);
      tick();
      check_eq("t4_second", {bus.o_ts_valid, bus.o_ts_fingerprint}, {1'b1, 20'h00006});
      bus.mac_ts_fingerprint = 20'h00077;
      sticky_clr = 1'b1;
      tick();
      bus.mac_ts_valid = 1'b0;
      sticky_clr = 1'b0;
      check_eq("t4_set_wins", sticky_unmatched, 1'b1);
      check_eq("t4_empty_nocomp", bus.o_ts_valid, 1'b0);
      check_eq("t4_cnt_unmatched", cnt_unmatched, exp_cnt(2));
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;

      // 5: push+pop while full, then match exactly on the expiry cycle
      for (int i = 0; i < 16; i++) begin
         bus.req_valid = 1'b1; bus.req_fingerprint = FP_W'(32'h200 + i);
         tick();
      end
      bus.req_valid = 1'b1; bus.req_fingerprint = 20'h002FF;
      bus.mac_ts_valid = 1'b1; bus.mac_ts_fingerprint = 20'h00200; bus.mac_ts_data = ts_of(60);
      tick();
      bus.req_valid = 1'b0;
      bus.mac_ts_valid = 1'b0;
      check_eq("t5_full_out", outstanding, 16);
      check_eq("t5_full_comp", {bus.o_ts_valid, bus.o_ts_fingerprint}, {1'b1, 20'h00200});
      check_eq("t5_no_ovf", sticky_ovf, 1'b0);
      repeat (TIMEOUT_CYC - 1) tick();
      bus.mac_ts_valid = 1'b1; bus.mac_ts_fingerprint = 20'h00201; bus.mac_ts_data = ts_of(61);
      tick();
      bus.mac_ts_valid = 1'b0;
      check_eq("t5_race_fp", {bus.o_ts_valid, bus.o_ts_fingerprint}, {1'b1, 20'h00201});
      check_eq("t5_race_data", bus.o_ts_data, ts_of(61));
      check_eq("t5_race_no_to", sticky_timeout, 1'b0);
      tick();
      check_eq("t5_no_sentinel", bus.o_ts_valid, 1'b0);
      check_eq("t5_outstanding", outstanding, 15);

      // 6: reset with entries queued discards them silently
      for (int i = 0; i < 10; i++) begin
         bus.mac_ts_valid = 1'b1;
         bus.mac_ts_fingerprint = FP_W'(32'h202 + i);
         bus.mac_ts_data = ts_of(70 + i);
         tick();
      end
      bus.mac_ts_valid = 1'b0;
      check_eq("t6_five", outstanding, 5);
      reset_n = 1'b0;
      #1;
      check_eq("t6_rst_out", outstanding, 0);
      check_eq("t6_rst_valid", bus.o_ts_valid, 1'b0);
      check_eq("t6_rst_fp", bus.o_ts_fingerprint, 0);
      check_eq("t6_rst_data", bus.o_ts_data, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      comp_base = n_comp;
      repeat (TIMEOUT_CYC + 10) tick();
      check_eq("t6_no_comp", 128'(n_comp - comp_base), 0);
      check_eq("t6_out_after", outstanding, 0);
      check_eq("t6_sticky_after", sticky_timeout, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
